// File: rtl/vend_credit_fsm_if.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm_if
//   Bundles the coin, selection, cancel and vend-transaction signals of the
//   vending credit controller.
//
//   Signals (as seen from the controller, modport slave):
//     coin_valid  in  1  single-cycle coin insertion strobe
//     coin_type   in  2  coin value code (0=5, 1=10, 2=25, 3=100 cents)
//     coin_reject out 1  one-cycle pulse, coin was not credited
//     sel_valid   in  1  single-cycle selection strobe
//     sel_item    in  2  selected item index
//     sel_deny    out 1  one-cycle pulse, credit insufficient
//     cancel      in  1  refund request (honoured only with VEND_CANCEL_EN)
//     credit      out 8  accumulated credit in cents
//     vend_valid  out 1  vend transaction presented
//     vend_ready  in  1  downstream accepts the transaction
//     vend_item   out 8  {6'b0, item} or 8'hFF for a refund
//     vend_change out 8  change owed in cents
//
//   modport master : the machine front panel / downstream side (drives inputs)
//   modport slave  : the credit controller
// ---------------------------------------------------------------------------
interface vend_credit_fsm_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_reject;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       sel_deny;
  logic       cancel;
  logic [7:0] credit;
  logic       vend_valid;
  logic       vend_ready;
  logic [7:0] vend_item;
  logic [7:0] vend_change;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_item, cancel, vend_ready,
    input  coin_reject, sel_deny, credit, vend_valid, vend_item, vend_change
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_item, cancel, vend_ready,
    output coin_reject, sel_deny, credit, vend_valid, vend_item, vend_change
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
//   Coin-credit and selection controller. Accumulates coin credit up to
//   CREDIT_MAX, checks a selection against a fixed four-entry price table and
//   presents a vend transaction (item code + change) on a valid/ready
//   handshake. All outputs come straight from flops.
//
//   Ports:
//     clk    in  1   rising-edge clock
//     rst_n  in  1   asynchronous active-low reset
//     bus    slave modport of vend_credit_fsm_if (coin / selection / cancel
//            inputs, credit and vend transaction outputs)
//
//   Parameters:
//     CREDIT_MAX (<= 255), PRICE_0..PRICE_3 in cents.
//
//   Optional feature macro:
//     VEND_CANCEL_EN - when defined, cancel in CREDIT refunds the whole credit
//                      as a vend transaction with vend_item = 8'hFF. When not
//                      defined, the cancel input is ignored.
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter int unsigned CREDIT_MAX = 200,
  parameter int unsigned PRICE_0    = 65,
  parameter int unsigned PRICE_1    = 75,
  parameter int unsigned PRICE_2    = 100,
  parameter int unsigned PRICE_3    = 125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vend_credit_fsm_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2
  } state_t;

  localparam logic [8:0] CREDIT_MAX_W = 9'(CREDIT_MAX);
  localparam logic [7:0] P0 = 8'(PRICE_0);
  localparam logic [7:0] P1 = 8'(PRICE_1);
  localparam logic [7:0] P2 = 8'(PRICE_2);
  localparam logic [7:0] P3 = 8'(PRICE_3);
  localparam logic [7:0] REFUND_CODE = 8'hFF;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] item_q, item_d;
  logic [7:0] change_q, change_d;
  logic       vend_valid_q, vend_valid_d;
  logic       coin_reject_q, coin_reject_d;
  logic       sel_deny_q, sel_deny_d;

  logic [7:0] coin_value;
  logic [7:0] price;
  logic [8:0] coin_sum;
  logic       coin_fits;
  logic       sel_ok;
  logic       cancel_req;

`ifdef VEND_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_req    = 1'b0;
`endif

  // Coin code to cents.
  always_comb begin
    coin_value = 8'd0;
    case (bus.coin_type)
      2'd0: coin_value = 8'd5;
      2'd1: coin_value = 8'd10;
      2'd2: coin_value = 8'd25;
      2'd3: coin_value = 8'd100;
    endcase
  end

  // Price table lookup for the current selection.
  always_comb begin
    price = P0;
    case (bus.sel_item)
      2'd0: price = P0;
      2'd1: price = P1;
      2'd2: price = P2;
      2'd3: price = P3;
    endcase
  end

  // Nine-bit sum so a coin that would push credit past 255 is still caught.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits = (coin_sum <= CREDIT_MAX_W);
  assign sel_ok    = (credit_q >= price);

  // Next-state and next-output logic. A refund or a sufficient selection
  // takes priority over a coin in the same cycle; the coin is then rejected
  // and the change is based on the pre-coin credit.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    change_d      = change_q;
    coin_reject_d = 1'b0;
    sel_deny_d    = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if ((state_q == CREDIT) && cancel_req) begin
          item_d        = REFUND_CODE;
          change_d      = credit_q;
          credit_d      = 8'd0;
          coin_reject_d = bus.coin_valid;
          state_d       = VEND;
        end else if ((state_q == CREDIT) && bus.sel_valid && sel_ok) begin
          item_d        = {6'b0, bus.sel_item};
          change_d      = credit_q - price;
          credit_d      = 8'd0;
          coin_reject_d = bus.coin_valid;
          state_d       = VEND;
        end else begin
          sel_deny_d = bus.sel_valid;
          if (bus.coin_valid) begin
            if (coin_fits) begin
              credit_d = coin_sum[7:0];
              state_d  = CREDIT;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end

      VEND: begin
        // Selections are ignored silently while a transaction is pending.
        coin_reject_d = bus.coin_valid;
        if (bus.vend_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    vend_valid_d = (state_d == VEND);
  end

  // State and output registers; reset drops any pending transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      credit_q      <= 8'd0;
      item_q        <= 8'd0;
      change_q      <= 8'd0;
      vend_valid_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_deny_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      change_q      <= change_d;
      vend_valid_q  <= vend_valid_d;
      coin_reject_q <= coin_reject_d;
      sel_deny_q    <= sel_deny_d;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.vend_item   = item_q;
  assign bus.vend_change = change_q;
  assign bus.vend_valid  = vend_valid_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_deny    = sel_deny_q;

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Coin-credit and selection controller for the vending machine datapath. Accumulates coin credit, accepts an item selection, checks it against a fixed price table, and issues a vend transaction carrying the 8-bit item code and 8-bit change amount. These two bytes are the operands the downstream vend packing stage concatenates into its 16-bit output word.

## Interface
Parameters:
- CREDIT_MAX, 200: maximum credit held, in cents; must be ≤ 255.
- PRICE_0, 65: price of item 0, in cents.
- PRICE_1, 75: price of item 1, in cents.
- PRICE_2, 100: price of item 2, in cents.
- PRICE_3, 125: price of item 3, in cents.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  single-cycle coin insertion strobe.
- coin_type  in  2  coin value: 0=5, 1=10, 2=25, 3=100 cents.
- coin_reject  out  1  one-cycle pulse; the coin was not credited.
- sel_valid  in  1  single-cycle selection strobe.
- sel_item  in  2  selected item index.
- sel_deny  out  1  one-cycle pulse; credit was insufficient for the selection.
- cancel  in  1  refund request; used only when VEND_CANCEL_EN is defined.
- credit  out  8  current accumulated credit, in cents.
- vend_valid  out  1  a vend transaction is presented.
- vend_ready  in  1  the downstream stage accepts the transaction.
- vend_item  out  8  {6'b0, item index}, or 8'hFF for a refund.
- vend_change  out  8  change owed, in cents.

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND (transaction pending).
- IDLE/CREDIT, coin_valid: if credit+coin ≤ CREDIT_MAX, credit += coin, go to CREDIT. Otherwise pulse coin_reject and leave credit unchanged.
- CREDIT, sel_valid, credit ≥ PRICE[sel_item]:
  - latch vend_item = {6'b0, sel_item} and vend_change = credit − PRICE.
  - clear credit to 0 and go to VEND.
- CREDIT, sel_valid, credit < PRICE: pulse sel_deny and stay in CREDIT.
- IDLE, sel_valid: pulse sel_deny.
- VEND: vend_valid=1; vend_item and vend_change are held stable until the handshake. When vend_valid && vend_ready, go to IDLE.
- VEND, coin_valid: pulse coin_reject. sel_valid is ignored, with no sel_deny.
- Same cycle coin_valid and a sufficient sel_valid: the selection wins, the coin is rejected, and change is computed from pre-coin credit.
- Same cycle coin_valid and an insufficient sel_valid: the coin is credited and sel_deny pulses.
- Arithmetic: the sum uses 9 bits for the overflow compare. Subtraction happens only when credit ≥ price, so it never underflows.

## Timing
- Reset values: state=IDLE, credit=0, vend_valid=0, vend_item=0, vend_change=0, coin_reject=0, sel_deny=0.
- All outputs are registered.
- Coin to credit update: 1 cycle.
- Selection to vend_valid: 1 cycle.
- Handshake to IDLE: vend_valid drops the cycle after vend_valid && vend_ready. Back-to-back transactions are impossible; the minimum is 1 IDLE cycle.
- coin_reject and sel_deny are high for exactly 1 cycle, the cycle after the offending strobe.
- An rst_n assertion in any state, including VEND with vend_ready low, immediately returns all outputs to reset values. The pending transaction is dropped.

## Configuration
- VEND_CANCEL_EN defined:
  - In CREDIT, cancel=1 loads vend_item=8'hFF and vend_change=credit, clears credit, and goes to VEND.
  - cancel beats a simultaneous sel_valid (no sel_deny) and a simultaneous coin (coin_reject).
  - cancel in IDLE or VEND is ignored.
- VEND_CANCEL_EN undefined: the cancel port is present but ignored; 8'hFF is never produced.

## Test plan
- Reset, insert 25,25,25 → credit 25/50/75. sel_item=1 → next cycle vend_valid=1, vend_item=8'h01, vend_change=0, credit=0.
- Insert 100, select item 0 with vend_ready held low 5 cycles → vend_item and vend_change (35) stay stable; vend_ready=1 → IDLE the next cycle. A coin during the hold gets coin_reject.
- Insert 100,100, then 5 (CREDIT_MAX=200) → third coin rejected, credit stays 200. Select item 3 → vend_change=75.
- Credit 50, select item 2 → sel_deny pulse, credit 50. Then same-cycle coin 25 plus select item 0 with credit 50 → coin credited (75), sel_deny.
- With VEND_CANCEL_EN: credit 40, cancel → vend_item=8'hFF, vend_change=40. Without it: cancel has no effect and credit stays 40.
- rst_n low mid-VEND → vend_valid and credit go to 0 asynchronously; after release, state is IDLE.
